shift_unit_arbiter: RTL and testbench
=====================================

# shift_unit_arbiter

Registered, shared 64-bit shift unit that arbitrates between two requesters (integer pipe = port 0, address/immediate unit = port 1). It issues at most one request per cycle through a single internal barrel-shift datapath (SLL/SRL/SRA, 64-bit and RV64 word forms). It returns the result on one shared response channel tagged with the requester ID. Round-robin arbitration gives fairness; valid/ready handshakes on both sides give backpressure.

## Interface
- `DATA_W`, 64: operand and result width; only 64 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present on port 0 / 1.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid & ready.
- `req0_op` / `req1_op`  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (executes as SRL).
- `req0_word` / `req1_word`  in  1  1 = 32-bit word form (SLLW/SRLW/SRAW).
- `req0_data` / `req1_data`  in  64  operand to shift.
- `req0_shamt` / `req1_shamt`  in  64  shift amount; only low 6 bits are used (low 5 in word mode).
- `rsp_valid`  out  1  result register holds a valid result.
- `rsp_ready`  in  1  consumer takes the result this cycle when valid & ready.
- `rsp_id`  out  1  requester that issued the held result.
- `rsp_data`  out  64  shifted result.

## Operation
- `can_accept = !rsp_valid || rsp_ready`.
- Arbitration (combinational):
  - Only one port valid: that port is granted.
  - Both ports valid: the port not in `last_grant` is granted.
  - `reqN_ready = grantN && can_accept`. At most one `reqN_ready` is high in any cycle.
- The ungranted port's ready is 0. The requester must hold valid and payload stable until accepted.
- On acceptance (a fire):
  - The result is computed from the granted payload.
  - `rsp_data`, `rsp_id` and `rsp_valid=1` are registered.
  - `last_grant` is set to the granted port.
- If no fire occurs and `rsp_ready` is high, `rsp_valid` is cleared. `rsp_data` and `rsp_id` keep their last value.
- If no fire occurs and `rsp_ready` is low, all response registers hold.
- 64-bit mode: `s = shamt[5:0]`.
  - SLL: `data << s`.
  - SRL: `data >> s`, zero-filled.
  - SRA: `data >> s`, filled with `data[63]`.
- Word mode: `s = shamt[4:0]`, and the operation uses `data[31:0]` only.
  - SRA fills with `data[31]`.
  - The 32-bit result is sign-extended from its bit 31 to 64 bits, for all three ops.
- Shift amount 0 returns the operand unchanged (word mode: sign-extended low word).
- The shift datapath is a log-stage (6-stage) barrel structure, not a behavioural `>>>`. SLL reuses the right-shift stages by bit reversal.

## Timing
- Reset values (asynchronous assertion, held while `rst`=1):
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0.
  - `last_grant`=1, so port 0 wins the first tie.
  - While `rst`=1, `req0_ready`=`req1_ready`=0.
- Latency: a request accepted at edge N has `rsp_valid`=1 with its result after edge N, i.e. visible in cycle N+1.
- Throughput: one result per cycle while `rsp_ready` stays high. Back-to-back fires overwrite the register on the same edge the old result is consumed.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, both readies are 0 and the response registers hold.
- Simultaneous consume and accept in one cycle: the new result replaces the old one and `rsp_valid` stays 1. No bubble.
- Contention: with both ports continuously valid and `rsp_ready`=1, grants alternate 0,1,0,1,… starting with port 0 after reset.
- Reset mid-operation: a held, unconsumed result is discarded (`rsp_valid`→0 immediately on `rst`). A request presented during reset is not accepted.

## Test plan
- Reset then idle: assert `rst` at cycle 3 with a response pending -> `rsp_valid`=0, `rsp_data`=0, both readies 0 during reset; after release, readies follow `valid` again.
- Single issue, port 0:
  - SRL, data 0x8000000000000000, shamt 65 -> ready same cycle; next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_data`=0x4000000000000000.
  - SRA with shamt 4 -> 0xF800000000000000.
  - SLL 0x1 with shamt 63 -> 0x8000000000000000.
- Word mode:
  - Port 1 SLLW 0x1 with shamt 31 -> 0xFFFFFFFF80000000.
  - SRAW data 0x0000000080000000 with shamt 36 (masked to 4) -> 0xFFFFFFFFF8000000.
  - SRLW same data with shamt 4 -> 0x0000000008000000.
- Contention: both ports valid for 4 cycles, `rsp_ready`=1 -> `rsp_id` sequence 0,1,0,1, one result per cycle, each port's payload unchanged until its ready.
- Backpressure: hold `rsp_ready`=0 for 3 cycles with a result pending -> `rsp_data` and `rsp_id` stable, readies 0. Raise `rsp_ready` together with a pending request -> same-edge replacement, `rsp_valid` stays 1.
- Identity and pattern: data 0xA0A0A0A0A0A0A0A0, SRL shamt 0 -> unchanged; SRL shamt 4 -> 0x0A0A0A0A0A0A0A0A; op=11 with shamt 4 -> same as SRL.

Source files
------------

// File: rtl/shift_unit_arbiter.sv
// Shared 64-bit shift unit with a round-robin arbiter for two requesters and a
// single registered, ID-tagged response channel with valid/ready backpressure.
module shift_unit_arbiter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic              req0_word,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req0_shamt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic              req1_word,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [DATA_W-1:0] req1_shamt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data
);

  localparam int HALF_W = DATA_W / 2;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic              last_grant;
  logic              can_accept;
  logic              grant0;
  logic              grant1;
  logic              fire;
  logic [1:0]        sel_op;
  logic              sel_word;
  logic [DATA_W-1:0] sel_data;
  logic [5:0]        sel_shamt;
  logic [5:0]        amt;
  logic              fill;
  logic              is_sll;
  logic [DATA_W-1:0] pre;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] post;
  logic [HALF_W-1:0] low_word;
  logic [DATA_W-1:0] result;
  logic              unused_shamt_hi;

  assign unused_shamt_hi = ^{req0_shamt[DATA_W-1:6], req1_shamt[DATA_W-1:6]};

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  // Port 0 wins unless port 1 is the only one asking or port 0 went last.
  always_comb begin
    can_accept = !rsp_valid || rsp_ready;
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && !grant0;
    req0_ready = grant0 && can_accept && !rst;
    req1_ready = grant1 && can_accept && !rst;
    fire       = req0_ready || req1_ready;
  end

  // Left shifts are bit-reversed into the right-shift stages and back out.
  always_comb begin
    sel_op    = grant1 ? req1_op         : req0_op;
    sel_word  = grant1 ? req1_word       : req0_word;
    sel_data  = grant1 ? req1_data       : req0_data;
    sel_shamt = grant1 ? req1_shamt[5:0] : req0_shamt[5:0];
    is_sll    = (sel_op == OP_SLL);
    amt       = sel_word ? {1'b0, sel_shamt[4:0]} : sel_shamt;
    fill      = (sel_op == OP_SRA) &&
                (sel_word ? sel_data[HALF_W-1] : sel_data[DATA_W-1]);
    if (is_sll)
      pre = bit_reverse(sel_word ? {sel_data[HALF_W-1:0], {HALF_W{1'b0}}} : sel_data);
    else
      pre = sel_word ? {{HALF_W{fill}}, sel_data[HALF_W-1:0]} : sel_data;

    shifted = pre;
    for (int k = 0; k < 6; k++) begin
      if (amt[k])
        shifted = (shifted >> (1 << k)) |
                  ({DATA_W{fill}} & ~({DATA_W{1'b1}} >> (1 << k)));
    end

    post     = is_sll ? bit_reverse(shifted) : shifted;
    low_word = is_sll ? post[DATA_W-1:HALF_W] : post[HALF_W-1:0];
    result   = sel_word ? {{HALF_W{low_word[HALF_W-1]}}, low_word} : post;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (fire) begin
      rsp_valid  <= 1'b1;
      rsp_data   <= result;
      rsp_id     <= grant1;
      last_grant <= grant1;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed plus randomized bench for shift_unit_arbiter, checked against an
// arithmetic reference of the shift ops and the round-robin grant rules.
module tb_shift_unit_arbiter;

  typedef struct packed {
    logic        v;
    logic [1:0]  op;
    logic        w;
    logic [63:0] d;
    logic [63:0] s;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_word;
  logic [1:0]  req0_op;
  logic [63:0] req0_data, req0_shamt;
  logic        req1_valid, req1_ready, req1_word;
  logic [1:0]  req1_op;
  logic [63:0] req1_data, req1_shamt;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [63:0] rsp_data;

  int errors = 0;
  int checks = 0;

  logic        m_valid, m_id, m_last;
  logic [63:0] m_data;
  logic        fire0, fire1;
  req_t        p0, p1;

  always #5 clk = ~clk;

  shift_unit_arbiter #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_word(req0_word), .req0_data(req0_data), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_word(req1_word), .req1_data(req1_data), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data)
  );

  function automatic logic [63:0] ref_shift(input req_t r);
    logic [31:0]        w;
    logic signed [31:0] sw;
    logic signed [63:0] sd;
    logic [63:0]        res;
    if (r.w) begin
      sw = r.d[31:0];
      case (r.op)
        2'b00:   w = r.d[31:0] << r.s[4:0];
        2'b10:   w = sw >>> r.s[4:0];
        default: w = r.d[31:0] >> r.s[4:0];
      endcase
      res = {{32{w[31]}}, w};
    end else begin
      sd = r.d;
      case (r.op)
        2'b00:   res = r.d << r.s[5:0];
        2'b10:   res = sd >>> r.s[5:0];
        default: res = r.d >> r.s[5:0];
      endcase
    end
    return res;
  endfunction

  function automatic req_t mk(input logic [1:0] op, input logic w,
                              input logic [63:0] d, input logic [63:0] s);
    req_t r;
    r.v = 1'b1; r.op = op; r.w = w; r.d = d; r.s = s;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_data = '0; m_last = 1'b1;
  endtask

  task automatic applyStimulus(input req_t a, input req_t b, input logic rr);
    req0_valid = a.v; req0_op = a.op; req0_word = a.w; req0_data = a.d; req0_shamt = a.s;
    req1_valid = b.v; req1_op = b.op; req1_word = b.w; req1_data = b.d; req1_shamt = b.s;
    rsp_ready  = rr;
  endtask

  // One clock cycle: check readies, let the edge happen, then check the response.
  task automatic checkOutput(input string tag);
    logic can, g0, g1;
    #1;
    can = !m_valid || rsp_ready;
    g0  = req0_valid && (!req1_valid || m_last == 1'b1);
    g1  = req1_valid && (!req0_valid || m_last == 1'b0);
    fire0 = g0 && can && !rst;
    fire1 = g1 && can && !rst;
    chk({tag, ".ready0"}, 64'(req0_ready), 64'(fire0));
    chk({tag, ".ready1"}, 64'(req1_ready), 64'(fire1));
    @(posedge clk);
    if (fire0 || fire1) begin
      m_data  = fire0 ? ref_shift(p0) : ref_shift(p1);
      m_id    = fire1;
      m_valid = 1'b1;
      m_last  = fire1;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".valid"}, 64'(rsp_valid), 64'(m_valid));
    chk({tag, ".id"},    64'(rsp_id),    64'(m_id));
    chk({tag, ".data"},  rsp_data,       m_data);
  endtask

  task automatic reset_midcycle(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    chk({tag, ".valid"},  64'(rsp_valid),  64'd0);
    chk({tag, ".data"},   rsp_data,        64'd0);
    chk({tag, ".ready0"}, 64'(req0_ready), 64'd0);
    chk({tag, ".ready1"}, 64'(req1_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input string tag, input req_t r, input logic port,
                       input logic [63:0] exp);
    req_t idle;
    idle = '0;
    p0 = port ? idle : r;
    p1 = port ? r : idle;
    applyStimulus(p0, p1, 1'b1);
    checkOutput(tag);
    chk({tag, ".const"}, rsp_data, exp);
    chk({tag, ".cid"},   64'(rsp_id), 64'(port));
  endtask

  initial begin
    p0 = '0; p1 = '0;
    rst = 1'b1;
    model_reset();
    applyStimulus(mk(2'b01, 1'b0, 64'h1, 64'd1), mk(2'b01, 1'b0, 64'h2, 64'd1), 1'b1);
    p0 = mk(2'b01, 1'b0, 64'h1, 64'd1);
    p1 = mk(2'b01, 1'b0, 64'h2, 64'd1);
    @(negedge clk);
    checkOutput("in_reset");
    rst = 1'b0;

    // A pending result is discarded by a reset in its third cycle.
    p0 = mk(2'b01, 1'b0, 64'h8000000000000000, 64'd65); p1 = '0;
    applyStimulus(p0, p1, 1'b0);
    checkOutput("pend1");
    chk("srl65.const", rsp_data, 64'h4000000000000000);
    p0 = mk(2'b00, 1'b0, 64'h5, 64'd2);
    applyStimulus(p0, p1, 1'b0);
    checkOutput("pend2");
    applyStimulus(p0, p1, 1'b0);
    reset_midcycle("rst_mid");
    applyStimulus(p0, p1, 1'b0);
    checkOutput("after_rst");

    issue("srl65", mk(2'b01, 1'b0, 64'h8000000000000000, 64'd65), 1'b0, 64'h4000000000000000);
    issue("sra4",  mk(2'b10, 1'b0, 64'h8000000000000000, 64'd4),  1'b0, 64'hF800000000000000);
    issue("sll63", mk(2'b00, 1'b0, 64'h1, 64'd63),                1'b0, 64'h8000000000000000);
    issue("sllw31", mk(2'b00, 1'b1, 64'h1, 64'd31),               1'b1, 64'hFFFFFFFF80000000);
    issue("sraw36", mk(2'b10, 1'b1, 64'h0000000080000000, 64'd36), 1'b1, 64'hFFFFFFFFF8000000);
    issue("srlw4",  mk(2'b01, 1'b1, 64'h0000000080000000, 64'd4),  1'b1, 64'h0000000008000000);
    issue("srl0",  mk(2'b01, 1'b0, 64'hA0A0A0A0A0A0A0A0, 64'd0),  1'b0, 64'hA0A0A0A0A0A0A0A0);
    issue("srl4",  mk(2'b01, 1'b0, 64'hA0A0A0A0A0A0A0A0, 64'd4),  1'b0, 64'h0A0A0A0A0A0A0A0A);
    issue("op11",  mk(2'b11, 1'b0, 64'hA0A0A0A0A0A0A0A0, 64'd4),  1'b0, 64'h0A0A0A0A0A0A0A0A);

    // Contention right after reset alternates starting with port 0.
    applyStimulus('0, '0, 1'b1);
    reset_midcycle("rst_cont");
    p0 = mk(2'b00, 1'b0, 64'h11, 64'd4);
    p1 = mk(2'b01, 1'b0, 64'hF00, 64'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(p0, p1, 1'b1);
      checkOutput("cont");
      chk("cont.seq", 64'(rsp_id), 64'(i % 2));
      if (fire0) p0 = mk(2'b00, 1'b0, 64'(i + 32), 64'd1);
      if (fire1) p1 = mk(2'b10, 1'b0, 64'hF000000000000000 | 64'(i), 64'd8);
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(p0, p1, 1'b0);
      checkOutput("bp");
    end
    applyStimulus(p0, p1, 1'b1);
    checkOutput("bp_release");
    chk("bp_release.stay", 64'(rsp_valid), 64'd1);

    for (int i = 0; i < 400; i++) begin
      if (!p0.v && $urandom_range(0, 2) != 0)
        p0 = mk(2'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      if (!p1.v && $urandom_range(0, 2) != 0)
        p1 = mk(2'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      applyStimulus(p0, p1, $urandom_range(0, 3) != 0);
      checkOutput("rnd");
      if (fire0) p0.v = 1'b0;
      if (fire1) p1.v = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
